// File: rtl/msdap_pkg.sv
// Shared sizes, coefficient record and FSM state type for the MSDAP
// operand-fetch stage and its history buffer.
package msdap_pkg;

  localparam int RJ_NUM     = 16;
  localparam int COEFF_NUM  = 512;
  localparam int DATA_DEPTH = 256;
  localparam int DW         = 16;

  localparam int RW = $clog2(RJ_NUM);     // rj group index width
  localparam int CW = $clog2(COEFF_NUM);  // coefficient table address width
  localparam int EW = 10;                 // cumulative end-index width (wraps)

  // One coefficient entry: sign (1 = negative) and delay k.
  typedef struct packed {
    logic       sign;
    logic [7:0] k;
  } coeff_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/msdap_hist_buf.sv
// Input-sample history ring buffer. New samples land at wr_ptr; reads
// address the sample k positions behind the newest one and return zero
// when fewer than k+1 samples have been received since reset.
module msdap_hist_buf
  import msdap_pkg::*;
#(
  parameter int DEPTH = DATA_DEPTH,
  parameter int W     = DW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  input  logic [7:0]   rd_k_i,
  output logic [W-1:0] rd_data_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NW   = AW + 1;
  localparam int CMPW = (NW > 8) ? NW : 8;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NW-1:0] n_cnt_q, n_cnt_d;
  logic [W-1:0]  rd_data_q;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;

  // Newest sample sits at wr_ptr-1; k steps further back, modulo depth.
  // Delays at or beyond the received-sample count read as zero, so stale
  // buffer contents left over from before reset never leak out.
  always_comb begin
    rd_addr  = wr_ptr_q - AW'(1) - AW'(rd_k_i);
    rd_hit   = CMPW'(rd_k_i) < CMPW'(n_cnt_q);
    wr_ptr_d = wr_ptr_q;
    n_cnt_d  = n_cnt_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (n_cnt_q != NW'(DEPTH)) n_cnt_d = n_cnt_q + NW'(1);
    end
  end

  // Sample storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_ptr_q] <= wr_data_i;
  end

  // Pointer, saturating fill count and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      n_cnt_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      n_cnt_q  <= n_cnt_d;
      if (rd_en_i) rd_data_q <= rd_hit ? mem[rd_addr] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/msdap_operand_fetch.sv
// MSDAP operand-fetch stage: holds the rj and coefficient tables, accepts
// one input sample per frame, then serves x(n-k) plus coefficient sign to
// the DA calculation stage on each request while tracking the cumulative
// end-coefficient index of the current rj group.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a sample; configuration writes accepted
//   ST_ACTIVE | frame in progress; serving data_req / next_end_req until
//             | frame_done; samples and config writes rejected (flagged)
module msdap_operand_fetch
  import msdap_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [8:0]    cfg_addr,
  input  logic [8:0]    cfg_wdata,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic          data_req,
  input  logic          next_end_req,
  input  logic          frame_done,
  output logic [DW-1:0] data_out,
  output logic          coeff_sign,
  output logic          data_valid,
  output logic [EW-1:0] end_coeff_idx,
  output logic          calc_start,
  output logic          busy,
  output logic [2:0]    err
);

  coeff_t     coeff_mem [COEFF_NUM];
  logic [7:0] rj_mem    [RJ_NUM];

  state_t        state_q, state_d;
  logic [EW-1:0] coeff_idx_q, coeff_idx_d;
  logic [RW-1:0] rj_idx_q, rj_idx_d;
  logic [EW-1:0] end_idx_q, end_idx_d;
  logic          calc_start_q, calc_start_d;
  logic          data_valid_q, data_valid_d;
  logic          sign_q, sign_d;
  logic [2:0]    err_q, err_d;

  logic          hist_we;
  logic          hist_rd;
  coeff_t        cur_coeff;
  logic [RW-1:0] rj_next;

  // The coefficient table wraps on its own depth; the index register is
  // wider only so the past-end comparison against end_coeff_idx works.
  assign cur_coeff = coeff_mem[coeff_idx_q[CW-1:0]];
  assign rj_next   = rj_idx_q + RW'(1);

  // Table writes are only honoured between frames.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == ST_IDLE)) begin
      if (cfg_sel) coeff_mem[cfg_addr[CW-1:0]] <= coeff_t'(cfg_wdata);
      else         rj_mem[cfg_addr[RW-1:0]]    <= cfg_wdata[7:0];
    end
  end

  // Next-state, index bookkeeping and sticky error flags.
  always_comb begin
    state_d      = state_q;
    coeff_idx_d  = coeff_idx_q;
    rj_idx_d     = rj_idx_q;
    end_idx_d    = end_idx_q;
    calc_start_d = 1'b0;
    data_valid_d = 1'b0;
    sign_d       = sign_q;
    err_d        = err_q;
    hist_we      = 1'b0;
    hist_rd      = 1'b0;

    if (cfg_we && (state_q == ST_ACTIVE)) err_d[1] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          hist_we      = 1'b1;
          coeff_idx_d  = '0;
          rj_idx_d     = '0;
          end_idx_d    = {2'b00, rj_mem[0]};
          calc_start_d = 1'b1;
          state_d      = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (sample_valid) err_d[0] = 1'b1;
        if (frame_done) begin
          state_d = ST_IDLE;
        end else begin
          // Requests use the pre-update indices even when next_end_req
          // arrives in the same cycle; an over-run request is still served.
          if (data_req) begin
            hist_rd      = 1'b1;
            data_valid_d = 1'b1;
            sign_d       = cur_coeff.sign;
            coeff_idx_d  = coeff_idx_q + EW'(1);
            if (coeff_idx_q >= end_idx_q) err_d[2] = 1'b1;
          end
          if (next_end_req && (rj_idx_q != RW'(RJ_NUM - 1))) begin
            rj_idx_d  = rj_next;
            end_idx_d = end_idx_q + {2'b00, rj_mem[rj_next]};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      coeff_idx_q  <= '0;
      rj_idx_q     <= '0;
      end_idx_q    <= '0;
      calc_start_q <= 1'b0;
      data_valid_q <= 1'b0;
      sign_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      coeff_idx_q  <= coeff_idx_d;
      rj_idx_q     <= rj_idx_d;
      end_idx_q    <= end_idx_d;
      calc_start_q <= calc_start_d;
      data_valid_q <= data_valid_d;
      sign_q       <= sign_d;
      err_q        <= err_d;
    end
  end

  msdap_hist_buf #(
    .DEPTH (DATA_DEPTH),
    .W     (DW)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (hist_we),
    .wr_data_i (sample_in),
    .rd_en_i   (hist_rd),
    .rd_k_i    (cur_coeff.k),
    .rd_data_o (data_out)
  );

  assign coeff_sign    = sign_q;
  assign data_valid    = data_valid_q;
  assign end_coeff_idx = end_idx_q;
  assign calc_start    = calc_start_q;
  assign busy          = (state_q == ST_ACTIVE);
  assign err           = err_q;

endmodule

// File: tb/tb_msdap_operand_fetch.sv
// Self-checking bench for msdap_operand_fetch. A reference model keeps the
// full sample history as a queue and recomputes cumulative rj sums directly.
module tb_msdap_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [8:0]  cfg_addr = '0;
  logic [8:0]  cfg_wdata = '0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        data_req = 1'b0;
  logic        next_end_req = 1'b0;
  logic        frame_done = 1'b0;
  logic [15:0] data_out;
  logic        coeff_sign;
  logic        data_valid;
  logic [9:0]  end_coeff_idx;
  logic        calc_start;
  logic        busy;
  logic [2:0]  err;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [15:0] m_hist[$];
  logic [7:0]  m_rj[16];
  logic        m_sign[512];
  logic [7:0]  m_k[512];
  bit          m_active;
  int          m_cidx;
  int          m_ridx;
  logic [9:0]  m_end;
  logic [2:0]  m_err;
  logic [15:0] m_dout;
  logic        m_dsign;
  logic        m_dvalid;
  logic        m_cstart;

  msdap_operand_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_sel       (cfg_sel),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .data_req      (data_req),
    .next_end_req  (next_end_req),
    .frame_done    (frame_done),
    .data_out      (data_out),
    .coeff_sign    (coeff_sign),
    .data_valid    (data_valid),
    .end_coeff_idx (end_coeff_idx),
    .calc_start    (calc_start),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] rj_sum(int upto);
    int s = 0;
    for (int i = 0; i <= upto; i++) s += int'(m_rj[i]);
    return 10'(s % 1024);
  endfunction

  function automatic logic [15:0] sample_at(int k);
    if (k < m_hist.size()) return m_hist[m_hist.size() - 1 - k];
    return 16'h0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_active = 0; m_cidx = 0; m_ridx = 0; m_end = '0; m_err = '0;
    m_dout = '0; m_dsign = 1'b0; m_dvalid = 1'b0; m_cstart = 1'b0;
  endtask

  task automatic do_reset();
    cfg_we = 0; sample_valid = 0; data_req = 0; next_end_req = 0; frame_done = 0;
    reset = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic cfg_write(input logic sel, input logic [8:0] addr, input logic [8:0] data);
    cfg_we = 1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    step();
    cfg_we = 0;
    m_dvalid = 0; m_cstart = 0;
    if (m_active) m_err[1] = 1'b1;
    else if (sel) begin m_sign[addr] = data[8]; m_k[addr] = data[7:0]; end
    else m_rj[addr[3:0]] = data[7:0];
  endtask

  // One clock with the given strobes, followed by the model's view of it.
  task automatic drive(input logic sv, input logic [15:0] x, input logic dr,
                       input logic ne, input logic fd);
    int c;
    sample_valid = sv; sample_in = x; data_req = dr; next_end_req = ne; frame_done = fd;
    step();
    sample_valid = 0; data_req = 0; next_end_req = 0; frame_done = 0;
    m_dvalid = 0; m_cstart = 0;
    if (!m_active) begin
      if (sv) begin
        m_hist.push_back(x);
        m_cidx = 0; m_ridx = 0; m_end = rj_sum(0);
        m_active = 1; m_cstart = 1;
      end
    end else begin
      if (sv) m_err[0] = 1'b1;
      if (fd) m_active = 0;
      else begin
        if (dr) begin
          c = m_cidx % 512;
          m_dout = sample_at(int'(m_k[c]));
          m_dsign = m_sign[c];
          m_dvalid = 1;
          if (m_cidx >= int'(m_end)) m_err[2] = 1'b1;
          m_cidx++;
        end
        if (ne && m_ridx < 15) begin
          m_ridx++;
          m_end = rj_sum(m_ridx);
        end
      end
    end
  endtask

  task automatic start_frame(input logic [15:0] x); drive(1, x, 0, 0, 0); endtask
  task automatic req();                             drive(0, 0, 1, 0, 0); endtask
  task automatic end_frame();                       drive(0, 0, 0, 0, 1); endtask

  task automatic load_default();
    for (int i = 0; i < 16; i++) cfg_write(0, 9'(i), 9'd32);
    for (int i = 0; i < 512; i++) cfg_write(1, 9'(i), {i[0], i[7:0]});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #3;
    tests++;
    if (busy !== 0 || data_valid !== 0 || calc_start !== 0 || err !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: busy=%b dv=%b cs=%b err=%b, want 0 0 0 000",
               busy, data_valid, calc_start, err);
    end
    tests++;
    if (data_out !== 16'h0 || coeff_sign !== 0 || end_coeff_idx !== 10'd0) begin
      fails++;
      $display("FAIL reset_data: data_out=%h sign=%b end=%0d, want 0 0 0",
               data_out, coeff_sign, end_coeff_idx);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic_frames();
    logic [15:0] want[4] = '{16'd3, 16'd2, 16'd1, 16'd0};
    load_default();
    start_frame(16'd1); end_frame();
    start_frame(16'd2); end_frame();
    start_frame(16'd3);
    tests++;
    if (calc_start !== 1 || busy !== 1 || end_coeff_idx !== 10'd32) begin
      fails++;
      $display("FAIL frame_start: cs=%b busy=%b end=%0d, want 1 1 32", calc_start, busy, end_coeff_idx);
    end
    for (int i = 0; i < 4; i++) begin
      req();
      tests++;
      if (data_valid !== 1 || data_out !== want[i] || data_out !== m_dout ||
          coeff_sign !== 1'(i % 2) || calc_start !== 0) begin
        fails++;
        $display("FAIL basic_k%0d: dv=%b data=%0d sign=%b, want 1 %0d %0d",
                 i, data_valid, data_out, coeff_sign, want[i], i % 2);
      end
    end
    step();
    tests++;
    if (data_valid !== 0 || data_out !== m_dout || coeff_sign !== m_dsign) begin
      fails++;
      $display("FAIL hold: dv=%b data=%0d sign=%b, want 0 %0d %b", data_valid, data_out,
               coeff_sign, m_dout, m_dsign);
    end
    end_frame();
    tests++;
    if (busy !== 0) begin
      fails++;
      $display("FAIL busy_fall: busy=%b want 0", busy);
    end
  endtask

  task automatic test_end_idx();
    logic [9:0] want;
    start_frame(16'd4);
    for (int p = 1; p <= 16; p++) begin
      drive(0, 0, 0, 1, 0);
      want = 10'((32 * ((p < 15 ? p : 15) + 1)) % 1024);
      tests++;
      if (end_coeff_idx !== want || end_coeff_idx !== m_end) begin
        fails++;
        $display("FAIL end_idx_p%0d: got %0d want %0d", p, end_coeff_idx, want);
      end
    end
    end_frame();
  endtask

  task automatic test_back_to_back_err2();
    do_reset();
    start_frame(16'h0100);
    for (int i = 0; i < 33; i++) begin
      data_req = 1;
      drive(0, 0, 1, 0, 0);
      tests++;
      if (data_valid !== 1 || data_out !== m_dout || coeff_sign !== m_dsign || err !== m_err) begin
        fails++;
        $display("FAIL b2b_%0d: dv=%b data=%h sign=%b err=%b, want 1 %h %b %b",
                 i, data_valid, data_out, coeff_sign, err, m_dout, m_dsign, m_err);
      end
    end
    tests++;
    if (err !== 3'b100) begin
      fails++;
      $display("FAIL err2: err=%b want 100", err);
    end
    end_frame();
  endtask

  task automatic test_ring_wrap();
    do_reset();
    cfg_write(1, 9'd1, 9'h0FF);
    for (int i = 1; i <= 300; i++) begin
      start_frame(16'(i));
      if (i < 300) end_frame();
    end
    req();
    tests++;
    if (data_out !== 16'd300 || data_out !== m_dout) begin
      fails++;
      $display("FAIL wrap_k0: got %0d want 300", data_out);
    end
    req();
    tests++;
    if (data_out !== 16'd45 || data_out !== m_dout) begin
      fails++;
      $display("FAIL wrap_k255: got %0d want 45", data_out);
    end
    end_frame();
    cfg_write(1, 9'd1, 9'h101);
  endtask

  task automatic test_overrun();
    do_reset();
    start_frame(16'h0A0A);
    drive(1, 16'hBEEF, 0, 0, 0);
    tests++;
    if (err !== 3'b001) begin
      fails++;
      $display("FAIL overrun: err=%b want 001", err);
    end
    drive(1, 16'hCAFE, 0, 0, 1);
    tests++;
    if (err !== 3'b001 || busy !== 0) begin
      fails++;
      $display("FAIL overrun_fd: err=%b busy=%b want 001 0", err, busy);
    end
    start_frame(16'h0B0B);
    req();
    req();
    tests++;
    if (data_out !== 16'h0A0A || data_out !== m_dout) begin
      fails++;
      $display("FAIL overrun_drop: k1 got %h want 0a0a", data_out);
    end
    end_frame();
  endtask

  task automatic test_cfg_busy();
    do_reset();
    start_frame(16'h0C0C);
    cfg_write(0, 9'd0, 9'd99);
    cfg_write(1, 9'd0, 9'h105);
    tests++;
    if (err !== 3'b010) begin
      fails++;
      $display("FAIL cfg_busy: err=%b want 010", err);
    end
    end_frame();
    start_frame(16'h0D0D);
    tests++;
    if (end_coeff_idx !== 10'd32) begin
      fails++;
      $display("FAIL cfg_rj_kept: end=%0d want 32", end_coeff_idx);
    end
    req();
    tests++;
    if (data_out !== 16'h0D0D || coeff_sign !== 0) begin
      fails++;
      $display("FAIL cfg_coeff_kept: data=%h sign=%b want 0d0d 0", data_out, coeff_sign);
    end
    end_frame();
  endtask

  task automatic test_reset_midframe();
    start_frame(16'h0E0E);
    drive(1, 16'h1111, 0, 0, 0);
    @(posedge clk);
    #2;
    data_req = 1;
    reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (busy !== 0 || data_valid !== 0 || err !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid: busy=%b dv=%b err=%b want 0 0 000", busy, data_valid, err);
    end
    step();
    tests++;
    if (data_valid !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL rst_mid_hold: dv=%b busy=%b want 0 0", data_valid, busy);
    end
    data_req = 0;
    reset = 1'b1;
    step();
    start_frame(16'h1234);
    req();
    tests++;
    if (data_out !== 16'h1234) begin
      fails++;
      $display("FAIL rst_mid_k0: got %h want 1234", data_out);
    end
    req();
    tests++;
    if (data_out !== 16'h0000 || coeff_sign !== 1) begin
      fails++;
      $display("FAIL rst_mid_k1: got %h sign %b want 0000 1", data_out, coeff_sign);
    end
    end_frame();
  endtask

  task automatic test_random();
    int ncyc;
    do_reset();
    for (int i = 0; i < 16; i++) cfg_write(0, 9'(i), 9'($urandom_range(0, 40)));
    for (int i = 0; i < 512; i++) cfg_write(1, 9'(i), 9'($urandom));
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(0, 9'($urandom_range(0, 15)), 9'($urandom_range(0, 40)));
      start_frame(16'($urandom));
      tests++;
      if (calc_start !== m_cstart || end_coeff_idx !== m_end || busy !== 1) begin
        fails++;
        $display("FAIL rnd_start_f%0d: cs=%b end=%0d busy=%b want %b %0d 1",
                 f, calc_start, end_coeff_idx, busy, m_cstart, m_end);
      end
      ncyc = $urandom_range(5, 40);
      for (int c = 0; c < ncyc; c++) begin
        if ($urandom_range(0, 19) == 0)
          cfg_write(1'($urandom), 9'($urandom), 9'($urandom));
        else
          drive($urandom_range(0, 19) == 0, 16'($urandom), 1'($urandom),
                $urandom_range(0, 3) == 0, 1'b0);
        tests++;
        if (data_valid !== m_dvalid || data_out !== m_dout || coeff_sign !== m_dsign) begin
          fails++;
          $display("FAIL rnd_data_f%0d_c%0d: dv=%b data=%h sign=%b want %b %h %b",
                   f, c, data_valid, data_out, coeff_sign, m_dvalid, m_dout, m_dsign);
        end
        tests++;
        if (end_coeff_idx !== m_end || err !== m_err || busy !== 1 || calc_start !== 0) begin
          fails++;
          $display("FAIL rnd_ctrl_f%0d_c%0d: end=%0d err=%b busy=%b cs=%b want %0d %b 1 0",
                   f, c, end_coeff_idx, err, busy, calc_start, m_end, m_err);
        end
      end
      drive(0, 0, 1'($urandom), 1'($urandom), 1'b1);
      tests++;
      if (busy !== 0 || data_valid !== 0 || end_coeff_idx !== m_end || err !== m_err) begin
        fails++;
        $display("FAIL rnd_end_f%0d: busy=%b dv=%b end=%0d err=%b want 0 0 %0d %b",
                 f, busy, data_valid, end_coeff_idx, err, m_end, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_end_idx();
    test_back_to_back_err2();
    test_ring_wrap();
    test_overrun();
    test_cfg_busy();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
